// File: rtl/ram_rd_arbiter.sv
// Front-end controller for one simple dual-port RAM: zero-fills the table,
// owns the write port for a config writer and round-robins the read port.
module ram_rd_arbiter #(
   parameter int unsigned RAM_WIDTH  = 32,
   parameter int unsigned RAM_DEPTH  = 16,
   parameter int unsigned ADDR_W     = $clog2(RAM_DEPTH),
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_clr,
   output logic                        o_init_done,
   input  logic                        i_wr_en,
   input  logic [ADDR_W-1:0]           i_wr_addr,
   input  logic [RAM_WIDTH-1:0]        i_wr_data,
   output logic                        o_wr_rdy,
   input  logic [NUM_REQ-1:0]          i_rd_req,
   input  logic [NUM_REQ*ADDR_W-1:0]   i_rd_addr,
   output logic [NUM_REQ-1:0]          o_rd_ack,
   output logic [NUM_REQ-1:0]          o_rd_vld,
   output logic [RAM_WIDTH-1:0]        o_rd_data,
   output logic [ADDR_W-1:0]           o_ram_addra,
   output logic [RAM_WIDTH-1:0]        o_ram_dina,
   output logic                        o_ram_wea,
   output logic [ADDR_W-1:0]           o_ram_addrb,
   output logic                        o_ram_enb,
   output logic                        o_ram_rstb,
   output logic                        o_ram_regceb,
   input  logic [RAM_WIDTH-1:0]        i_ram_doutb
);

   localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                armed_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [ADDR_W-1:0]   clr_cnt_d;
   logic [GNT_W-1:0]    last_gnt_q;
   logic [GNT_W-1:0]    gnt_idx;
   logic [GNT_W-1:0]    cand_idx;
   logic                gnt_any;
   logic [NUM_REQ-1:0]  gnt_oh;
   logic [ADDR_W-1:0]   gnt_addr;
   logic [ADDR_W-1:0]   addrb_q;
   logic [NUM_REQ-1:0]  vld_sr_q [RD_LATENCY];

   // State, clear counter, arbiter pointer and held read address.
   // armed_q keeps IDLE for one full cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         armed_q    <= 1'b0;
         clr_cnt_q  <= '0;
         last_gnt_q <= GNT_W'(NUM_REQ - 1);
         addrb_q    <= '0;
      end else begin
         state_q   <= state_d;
         armed_q   <= 1'b1;
         clr_cnt_q <= clr_cnt_d;
         if (gnt_any) begin
            last_gnt_q <= gnt_idx;
            addrb_q    <= gnt_addr;
         end
      end
   end

   // Next state and write-port control.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      o_init_done = 1'b0;
      o_wr_rdy    = 1'b0;
      o_ram_wea   = 1'b0;
      o_ram_addra = '0;
      o_ram_dina  = '0;
      case (state_q)
         IDLE: begin
            if (armed_q) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         CLEAR: begin
            o_ram_wea   = 1'b1;
            o_ram_addra = clr_cnt_q;
            if (i_clr) begin
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            o_init_done = 1'b1;
            o_wr_rdy    = i_wr_en;
            o_ram_wea   = i_wr_en;
            o_ram_addra = i_wr_addr;
            o_ram_dina  = i_wr_data;
            if (i_clr) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Round-robin search starting just after the last winner.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = last_gnt_q;
      cand_idx = '0;
      if (state_q == RUN) begin
         for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_idx = GNT_W'((32'(last_gnt_q) + i) % NUM_REQ);
            if (!gnt_any && i_rd_req[cand_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = cand_idx;
            end
         end
      end
   end

   assign gnt_oh   = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign gnt_addr = i_rd_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];

   assign o_rd_ack     = gnt_oh;
   assign o_ram_enb    = gnt_any;
   assign o_ram_addrb  = gnt_any ? gnt_addr : addrb_q;
   assign o_ram_rstb   = 1'b0;
   assign o_ram_regceb = 1'b1;

   // Grant tag travels alongside the RAM read pipeline; only reset drops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            vld_sr_q[i] <= '0;
         end
      end else begin
         vld_sr_q[0] <= gnt_oh;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_sr_q[i] <= vld_sr_q[i-1];
         end
      end
   end

   assign o_rd_vld  = vld_sr_q[RD_LATENCY-1];
   assign o_rd_data = i_ram_doutb;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Directed bench for ram_rd_arbiter: one instance per read latency (1 and 2),
// each in front of a behavioural RAM model, driven by the same stimulus.
module tb_ram_rd_arbiter;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  rd_req;
   logic [15:0] rd_addr;

   logic        init1, wrdy1, wea1, enb1, rstb1, regceb1;
   logic [3:0]  ack1, vld1, addra1, addrb1;
   logic [31:0] data1, dina1, dout1;
   logic        init2, wrdy2, wea2, enb2, rstb2, regceb2;
   logic [3:0]  ack2, vld2, addra2, addrb2;
   logic [31:0] data2, dina2, dout2, st2;

   logic [31:0] mem1 [16];
   logic [31:0] mem2 [16];

   int n_asserts;
   int n_fail;
   logic [3:0]  h1_ack, h2_ack;
   logic [31:0] h1_dat, h2_dat;
   logic [3:0]  rr_seq [7];

   ram_rd_arbiter #(.RAM_WIDTH(32), .RAM_DEPTH(16), .NUM_REQ(4), .RD_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_clr(clr), .o_init_done(init1),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_rdy(wrdy1),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(ack1), .o_rd_vld(vld1),
      .o_rd_data(data1), .o_ram_addra(addra1), .o_ram_dina(dina1), .o_ram_wea(wea1),
      .o_ram_addrb(addrb1), .o_ram_enb(enb1), .o_ram_rstb(rstb1),
      .o_ram_regceb(regceb1), .i_ram_doutb(dout1));

   ram_rd_arbiter #(.RAM_WIDTH(32), .RAM_DEPTH(16), .NUM_REQ(4), .RD_LATENCY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_clr(clr), .o_init_done(init2),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_rdy(wrdy2),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(ack2), .o_rd_vld(vld2),
      .o_rd_data(data2), .o_ram_addra(addra2), .o_ram_dina(dina2), .o_ram_wea(wea2),
      .o_ram_addrb(addrb2), .o_ram_enb(enb2), .o_ram_rstb(rstb2),
      .o_ram_regceb(regceb2), .i_ram_doutb(dout2));

   // LOW_LATENCY RAM: read-first, one output register
   always @(posedge clk) begin
      if (wea1) mem1[addra1] <= dina1;
      if (enb1) dout1 <= mem1[addrb1];
   end

   // HIGH_PERFORMANCE RAM: extra output register behind regceb/rstb
   always @(posedge clk) begin
      if (wea2) mem2[addra2] <= dina2;
      if (enb2) st2 <= mem2[addrb2];
      if (rstb2) dout2 <= '0;
      else if (regceb2) dout2 <= st2;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] want);
      n_asserts++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle check; read-return expectations come from the ack history.
   task automatic check(input string tag, input logic exp_init, input logic exp_wrdy,
                        input logic [3:0] exp_ack, input logic [31:0] exp_dat);
      logic [3:0] exp_addr;
      exp_addr = '0;
      for (int j = 0; j < 4; j++) begin
         if (exp_ack[j]) exp_addr = rd_addr[j*4 +: 4];
      end
      #1;
      chk(tag, "init1", init1, exp_init);
      chk(tag, "init2", init2, exp_init);
      chk(tag, "wr_rdy", wrdy1, exp_wrdy);
      chk(tag, "ack1", ack1, exp_ack);
      chk(tag, "ack2", ack2, exp_ack);
      chk(tag, "enb", enb1, |exp_ack);
      if (exp_ack != 4'b0) chk(tag, "addrb", addrb1, exp_addr);
      chk(tag, "vld1", vld1, h1_ack);
      if (h1_ack != 4'b0) chk(tag, "data1", data1, h1_dat);
      chk(tag, "vld2", vld2, h2_ack);
      if (h2_ack != 4'b0) chk(tag, "data2", data2, h2_dat);
      h2_ack = h1_ack;
      h2_dat = h1_dat;
      h1_ack = exp_ack;
      h1_dat = exp_dat;
   endtask

   // Release reset, then one IDLE cycle and sixteen ordered zero writes.
   task automatic init_seq(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         check(tag, 1'b0, 1'b0, 4'b0, 32'h0);
         chk(tag, "wea1", wea1, (k >= 1));
         chk(tag, "wea2", wea2, (k >= 1));
         chk(tag, "addra", addra1, (k >= 1) ? 32'(k - 1) : 32'h0);
         chk(tag, "dina", dina1, 32'h0);
      end
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      h1_ack = '0; h2_ack = '0; h1_dat = '0; h2_dat = '0;
      rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = '0; rd_addr = '0;

      #3;
      chk("reset", "init", init1, 1'b0);
      chk("reset", "vld", vld1, 4'b0);
      chk("reset", "ack", ack1, 4'b0);
      chk("reset", "wr_rdy", wrdy1, 1'b0);
      chk("reset", "wea", wea1, 1'b0);
      chk("reset", "enb", enb1, 1'b0);
      chk("reset", "addra", addra1, 4'h0);
      chk("reset", "addrb", addrb1, 4'h0);
      chk("reset", "dina", dina1, 32'h0);
      chk("reset", "rstb", rstb1, 1'b0);
      chk("reset", "regceb", regceb2, 1'b1);

      // Requests and writes held throughout CLEAR must be ignored.
      rd_addr = {4'd7, 4'd6, 4'd5, 4'd3};
      rd_req  = 4'hF;
      wr_en   = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
      #1;
      chk("reset_req", "ack", ack1, 4'b0);
      init_seq("por");

      // First RUN cycle: requester 0 wins, then strict rotation.
      tick(); wr_en = 1'b0;
      check("rr0", 1'b1, 1'b0, 4'b0001, 32'h0);
      for (int c = 0; c < 7; c++) begin
         tick();
         check("rr", 1'b1, 1'b0, rr_seq[c], 32'h0);
      end

      // Config write; read address holds the last grant (requester 3, addr 7).
      tick(); rd_req = 4'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_0003;
      check("wr3", 1'b1, 1'b1, 4'b0, 32'h0);
      chk("wr3", "wea", wea1, 1'b1);
      chk("wr3", "addra", addra1, 4'd3);
      chk("wr3", "dina", dina1, 32'hA5A5_0003);
      chk("wr3", "addrb_hold", addrb1, 4'd7);

      tick(); wr_en = 1'b0; rd_req = 4'b0100; rd_addr = {4'd7, 4'd3, 4'd5, 4'd3};
      check("rd3", 1'b1, 1'b0, 4'b0100, 32'hA5A5_0003);
      tick(); rd_req = 4'b0;
      check("flush", 1'b1, 1'b0, 4'b0, 32'h0);
      tick();
      check("flush", 1'b1, 1'b0, 4'b0, 32'h0);

      // Same-cycle write and read of addr 5 returns the old value.
      tick(); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11;
      rd_req = 4'b0001; rd_addr = {4'd7, 4'd3, 4'd5, 4'd5};
      check("raw", 1'b1, 1'b1, 4'b0001, 32'h0);
      tick(); wr_en = 1'b0;
      check("raw_next", 1'b1, 1'b0, 4'b0001, 32'h11);

      // Grant requester 1, then clear while its read is in flight.
      tick(); rd_req = 4'b0010; rd_addr = {4'd7, 4'd3, 4'd3, 4'd5};
      check("pre_clr", 1'b1, 1'b0, 4'b0010, 32'hA5A5_0003);
      tick(); rd_req = 4'b0; clr = 1'b1;
      check("clr_cycle", 1'b1, 1'b0, 4'b0, 32'h0);
      for (int k = 0; k < 16; k++) begin
         tick(); clr = 1'b0; rd_req = 4'hF;
         wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hFFFF_FFFF;
         check("clearing", 1'b0, 1'b0, 4'b0, 32'h0);
      end

      // Every entry reads back zero, including the ones written before.
      for (int i = 0; i < 16; i++) begin
         tick(); wr_en = 1'b0; rd_req = 4'b1000;
         rd_addr = {4'(i), 4'd3, 4'd3, 4'd5};
         check("readback", 1'b1, 1'b0, 4'b1000, 32'h0);
      end
      tick(); rd_req = 4'b0;
      check("flush2", 1'b1, 1'b0, 4'b0, 32'h0);
      tick();
      check("flush2", 1'b1, 1'b0, 4'b0, 32'h0);

      // Reset with a read in flight: its valid must never appear.
      tick(); rd_req = 4'b0001;
      check("pre_rst", 1'b1, 1'b0, 4'b0001, 32'h0);
      rst_n = 1'b0;
      h1_ack = '0; h2_ack = '0;
      #1;
      chk("rst_async", "vld1", vld1, 4'b0);
      chk("rst_async", "init", init1, 1'b0);
      chk("rst_async", "ack", ack1, 4'b0);
      rd_req = 4'hF; wr_en = 1'b1;
      tick();
      check("in_rst", 1'b0, 1'b0, 4'b0, 32'h0);
      init_seq("rerun");

      tick(); wr_en = 1'b0;
      check("post_rst", 1'b1, 1'b0, 4'b0001, 32'h0);
      tick(); rd_req = 4'b0;
      check("post_rst", 1'b1, 1'b0, 4'b0, 32'h0);
      tick();
      check("post_rst", 1'b1, 1'b0, 4'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
